move_cmd_sequencer: RTL and testbench

//  Sequences a queued list of 16-bit Knight commands (cal, move, move-with-fanfare) into RemoteComm.

---
 rtl/tour_pkg.sv | 39 +++
 rtl/cmd_fifo.sv | 67 ++++++
 rtl/move_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_move_cmd_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
//   seq_state_t   : sequencer FSM states
//   err_code_t    : error code reported on err_code_o
//   POS_ACK_DEF   : response byte meaning "command accepted"
//   TMO_CLKS_DEF  : default response timeout in clocks
//   OP_*          : command opcodes carried in cmd[15:12]
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        DONE,
        ERR
    } seq_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_BAD_ACK = 2'b01;
    localparam err_code_t ERR_TIMEOUT = 2'b10;
    localparam err_code_t ERR_ABORTED = 2'b11;

    localparam int unsigned CMD_W = 16;
    localparam int unsigned TMO_W = 27;

    localparam logic [7:0]       POS_ACK_DEF  = 8'hA5;
    localparam logic [TMO_W-1:0] TMO_CLKS_DEF = 27'd67108863;

    localparam logic [3:0] OP_CAL_GYRO = 4'h2;
    localparam logic [3:0] OP_MOVE     = 4'h4;
    localparam logic [3:0] OP_FANFARE  = 4'h5;

    function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1:CMD_W-4];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH x W.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : empty the FIFO (wins over push/pop in the same clock)
//   push_i/data_i  : enqueue; dropped silently when full
//   pop_i          : dequeue; ignored when empty
//   head_o         : oldest entry
//   full_o/empty_o : occupancy flags
module cmd_fifo
    import tour_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = CMD_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/move_cmd_sequencer.sv
// Feeds queued Knight commands to RemoteComm one at a time, waiting for a
// positive ack before sending the next; aborts on bad ack, timeout or abort_i.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   push_i, push_cmd_i      : enqueue a command (dropped when full_o)
//   full_o, empty_o         : command FIFO flags
//   start_i                 : begin draining the FIFO (from IDLE/DONE/ERR)
//   abort_i                 : flush FIFO; mid-tour, stop after current ack
//   cmd_o, snd_cmd_o        : command word and one-clock send strobe
//   cmd_snt_i               : RemoteComm finished transmitting
//   resp_rdy_i, resp_i      : response byte strobe and value
//   busy_o, done_o, err_o   : tour status (done/err held until start/rst)
//   err_code_o              : 00 none, 01 bad ack, 10 timeout, 11 aborted
//   n_acked_o               : positive acks since last start (saturating)
//
// state     | meaning
// IDLE      | after reset, waiting for start
// SEND      | pop FIFO head into cmd, strobe snd_cmd
// WAIT_SNT  | waiting for RemoteComm to finish transmitting
// WAIT_RESP | waiting for response byte, timeout running
// DONE      | FIFO drained, every command acked
// ERR       | tour stopped: bad ack, timeout or abort
module move_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int unsigned      DEPTH    = 8,
    parameter logic [7:0]       POS_ACK  = POS_ACK_DEF,
    parameter logic [TMO_W-1:0] TMO_CLKS = TMO_CLKS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [CMD_W-1:0] push_cmd_i,
    output logic             full_o,
    output logic             empty_o,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             snd_cmd_o,
    input  logic             cmd_snt_i,
    input  logic             resp_rdy_i,
    input  logic [7:0]       resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [7:0]       n_acked_o
);

    seq_state_t       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             snd_q, snd_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    err_code_t        code_q, code_d;
    logic [7:0]       nack_q, nack_d;
    logic             abort_pend_q, abort_pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             is_busy;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (abort_i),
        .push_i      (push_i),
        .push_data_i (push_cmd_i),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign is_busy = (state_q == SEND) || (state_q == WAIT_SNT) || (state_q == WAIT_RESP);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        snd_d        = 1'b0;
        done_d       = done_q;
        err_d        = err_q;
        code_d       = code_q;
        nack_d       = nack_q;
        abort_pend_d = abort_pend_q;
        tmo_d        = tmo_q;
        fifo_pop     = 1'b0;

        if (is_busy && abort_i) abort_pend_d = 1'b1;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    code_d       = ERR_NONE;
                    nack_d       = 8'd0;
                    abort_pend_d = 1'b0;
                    // An abort in the same clock flushes the FIFO, so treat it as empty.
                    if (fifo_empty || abort_i) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                cmd_d    = fifo_head;
                fifo_pop = 1'b1;
                snd_d    = 1'b1;
                state_d  = WAIT_SNT;
            end
            WAIT_SNT: begin
                if (cmd_snt_i) begin
                    // Down-counter: TMO_CLKS WAIT_RESP clocks are allowed for the response.
                    tmo_d   = TMO_CLKS - TMO_W'(1);
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (resp_rdy_i) begin
                    if (resp_i == POS_ACK) begin
                        nack_d = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
                        if (abort_pend_q || abort_i) begin
                            state_d      = ERR;
                            err_d        = 1'b1;
                            code_d       = ERR_ABORTED;
                            abort_pend_d = 1'b0;
                        end else if (!fifo_empty) begin
                            state_d = SEND;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d      = ERR;
                        err_d        = 1'b1;
                        code_d       = ERR_BAD_ACK;
                        abort_pend_d = 1'b0;
                    end
                end else if (tmo_q == '0) begin
                    state_d      = ERR;
                    err_d        = 1'b1;
                    code_d       = ERR_TIMEOUT;
                    abort_pend_d = 1'b0;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            snd_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            nack_q       <= 8'd0;
            abort_pend_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            snd_q        <= snd_d;
            done_q       <= done_d;
            err_q        <= err_d;
            code_q       <= code_d;
            nack_q       <= nack_d;
            abort_pend_q <= abort_pend_d;
            tmo_q        <= tmo_d;
        end
    end

    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign cmd_o      = cmd_q;
    assign snd_cmd_o  = snd_q;
    assign busy_o     = is_busy;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign n_acked_o  = nack_q;

endmodule

// File: tb/tb_move_cmd_sequencer.sv
module tb_move_cmd_sequencer;

    localparam int         DEPTH = 8;
    localparam int         TMO_T = 100;
    localparam logic [7:0] ACK   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_i = 1'b0;
    logic [15:0] push_cmd_i = '0;
    logic        full_o, empty_o;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] cmd_o;
    logic        snd_cmd_o;
    logic        cmd_snt_i = 1'b0;
    logic        resp_rdy_i = 1'b0;
    logic [7:0]  resp_i = '0;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [7:0]  n_acked_o;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [7:0] nack;
        logic       empty;
    } res_t;

    logic [15:0] exp_cmd_q[$];
    res_t        exp_res_q[$];
    logic [15:0] fixed_cmds[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    move_cmd_sequencer #(
        .DEPTH    (DEPTH),
        .POS_ACK  (ACK),
        .TMO_CLKS (27'(TMO_T))
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .push_i     (push_i),
        .push_cmd_i (push_cmd_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cmd_o      (cmd_o),
        .snd_cmd_o  (snd_cmd_o),
        .cmd_snt_i  (cmd_snt_i),
        .resp_rdy_i (resp_rdy_i),
        .resp_i     (resp_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .n_acked_o  (n_acked_o)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no/unexpected event, expected other behaviour", name);
    endfunction

    // Monitor: every snd_cmd strobe must carry the next expected command, and
    // every rise of done|err must match the next expected tour result.
    initial begin : monitor
        logic        prev_fin;
        logic        fin;
        logic [15:0] e;
        res_t        r;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (snd_cmd_o) begin
                if (exp_cmd_q.size() == 0) note_fail("unexpected_snd_cmd");
                else begin
                    e = exp_cmd_q.pop_front();
                    chk("cmd_order", 32'(cmd_o), 32'(e));
                end
            end
            fin = done_o | err_o;
            if (fin && !prev_fin) begin
                if (exp_res_q.size() == 0) note_fail("unexpected_finish");
                else begin
                    r = exp_res_q.pop_front();
                    chk("done",     32'(done_o),     32'(r.done));
                    chk("err",      32'(err_o),      32'(r.err));
                    chk("err_code", 32'(err_code_o), 32'(r.code));
                    chk("n_acked",  32'(n_acked_o),  32'(r.nack));
                    chk("empty_at_end", 32'(empty_o), 32'(r.empty));
                end
            end
            prev_fin = fin;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    // Pushes n commands, predicts the tour from the rules (ack, bad ack,
    // timeout, abort), then plays RemoteComm for every command that goes out.
    // fail_kind: 1 = bad ack, 2 = timeout.  -1 index means "never".
    task automatic run_tour(input int n, input int fail_idx, input int fail_kind,
                            input int abort_idx, input logic [7:0] bad);
        logic [15:0] acc[$];
        logic [15:0] c;
        res_t        r;
        int          s, nsent, k, t;
        for (int j = 0; j < n; j++) begin
            c = (j < fixed_cmds.size()) ? fixed_cmds[j] : 16'($urandom);
            push_i = 1'b1;
            push_cmd_i = c;
            @(negedge clk);
            if (acc.size() < DEPTH) acc.push_back(c);
            chk("full_flag",  32'(full_o),  32'(acc.size() == DEPTH));
            chk("empty_flag", 32'(empty_o), 32'(acc.size() == 0));
        end
        push_i = 1'b0;
        fixed_cmds.delete();

        s = -1;
        for (int i = 0; i < acc.size(); i++) begin
            if (i == fail_idx || i == abort_idx) begin
                s = i;
                break;
            end
        end
        nsent   = (s < 0) ? acc.size() : s + 1;
        for (int i = 0; i < nsent; i++) exp_cmd_q.push_back(acc[i]);
        r.done  = (s < 0);
        r.err   = (s >= 0);
        r.code  = (s < 0) ? 2'd0 : ((s == fail_idx) ? 2'(fail_kind) : 2'd3);
        r.nack  = (s < 0) ? 8'(acc.size()) : ((s == fail_idx) ? 8'(s) : 8'(s + 1));
        r.empty = (s < 0) || (s == abort_idx) || (s == acc.size() - 1);
        exp_res_q.push_back(r);

        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 1;
        for (int i = 0; i < nsent; i++) begin
            while (!snd_cmd_o && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (!snd_cmd_o) begin
                note_fail("snd_cmd_wait");
                break;
            end
            chk("snd_latency", 32'(k), 32'd2);
            // A response before cmd_snt must be ignored.
            if ($urandom_range(3) == 0) begin
                resp_rdy_i = 1'b1;
                resp_i = ACK;
                @(negedge clk);
                resp_rdy_i = 1'b0;
            end else begin
                repeat ($urandom_range(2)) @(negedge clk);
            end
            cmd_snt_i = 1'b1;
            t = 0;
            @(negedge clk);
            cmd_snt_i = 1'b0;
            t = 1;
            if (i == abort_idx) begin
                abort_i = 1'b1;
                @(negedge clk);
                abort_i = 1'b0;
                t++;
            end
            if (i == fail_idx && fail_kind == 2) begin
                while (!err_o && t < TMO_T + 20) begin
                    @(negedge clk);
                    t++;
                end
                // First negedge after the edge sampling cmd_snt is t=1.
                chk("timeout_clks", 32'(t), 32'(TMO_T + 1));
            end else begin
                repeat ($urandom_range(3)) @(negedge clk);
                resp_rdy_i = 1'b1;
                resp_i = (i == fail_idx) ? bad : ACK;
                @(negedge clk);
                resp_rdy_i = 1'b0;
                resp_i = '0;
                k = 1;
            end
        end

        t = 0;
        while (busy_o && t < TMO_T + 60) begin
            @(negedge clk);
            t++;
        end
        if (busy_o) note_fail("tour_end_wait");
        @(negedge clk);
        chk("results_pending", 32'(exp_res_q.size()), 32'd0);
        chk("cmds_pending",    32'(exp_cmd_q.size()), 32'd0);
        exp_cmd_q.delete();
        exp_res_q.delete();
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("flush_empty", 32'(empty_o), 32'd1);
    endtask

    initial begin : main
        logic [15:0] c0;
        int          k;

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_busy",     32'(busy_o),     32'd0);
        chk("rst_done",     32'(done_o),     32'd0);
        chk("rst_err",      32'(err_o),      32'd0);
        chk("rst_err_code", 32'(err_code_o), 32'd0);
        chk("rst_n_acked",  32'(n_acked_o),  32'd0);
        chk("rst_empty",    32'(empty_o),    32'd1);
        chk("rst_full",     32'(full_o),     32'd0);
        chk("rst_snd_cmd",  32'(snd_cmd_o),  32'd0);
        chk("rst_cmd",      32'(cmd_o),      32'd0);

        fixed_cmds.push_back(16'h43F2);
        fixed_cmds.push_back(16'h5001);
        run_tour(2, -1, 1, -1, 8'h00);            // two acked commands
        run_tour(DEPTH + 1, -1, 1, -1, 8'h00);    // overflow push dropped
        run_tour(2, 0, 1, -1, 8'h5A);             // bad ack on first
        run_tour(1, 0, 2, -1, 8'h00);             // timeout
        run_tour(3, -1, 1, 0, 8'h00);             // abort during first WAIT_RESP

        // Reset while waiting for cmd_snt.
        for (int j = 0; j < 2; j++) begin
            push_i = 1'b1;
            push_cmd_i = 16'($urandom);
            if (j == 0) begin
                c0 = push_cmd_i;
                exp_cmd_q.push_back(c0);
            end
            @(negedge clk);
        end
        push_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 1;
        while (!snd_cmd_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!snd_cmd_o) note_fail("rst_case_snd_wait");
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_busy",    32'(busy_o),    32'd0);
        chk("midrst_empty",   32'(empty_o),   32'd1);
        chk("midrst_snd_cmd", 32'(snd_cmd_o), 32'd0);
        cmd_snt_i = 1'b1;
        @(negedge clk);
        cmd_snt_i = 1'b0;
        resp_rdy_i = 1'b1;
        resp_i = ACK;
        @(negedge clk);
        resp_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_resp_busy",    32'(busy_o),    32'd0);
        chk("late_resp_n_acked", 32'(n_acked_o), 32'd0);
        chk("late_resp_done",    32'(done_o),    32'd0);
        chk("late_resp_err",     32'(err_o),     32'd0);
        chk("midrst_cmds_pending", 32'(exp_cmd_q.size()), 32'd0);
        exp_cmd_q.delete();

        run_tour(0, -1, 1, -1, 8'h00);            // start with empty FIFO

        for (int it = 0; it < 30; it++) begin
            int         n, f, a, kind, sel;
            logic [7:0] b;
            n    = $urandom_range(DEPTH + 2, 1);
            f    = -1;
            a    = -1;
            kind = 1;
            sel  = $urandom_range(3, 0);
            if (sel == 1 || sel == 3) f = $urandom_range(n - 1, 0);
            if (sel >= 2) a = $urandom_range(n - 1, 0);
            if (f >= 0 && $urandom_range(3, 0) == 0) kind = 2;
            do b = 8'($urandom); while (b == ACK);
            run_tour(n, f, kind, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
